// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer.
// Holds the confirm/commit state encoding.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO,
        CONF_HI,
        ST_HI,
        CONF_LO
    } debounce_state_e;

endpackage

// File: rtl/debounce_sync.sv
// Plain flop-chain synchronizer for one async bit.
// No reset: stale contents are filtered downstream.
module sync #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic sync_i,
    output logic sync_o
);

    if (Stages < 2) begin : g_drc_stages
        $error("sync: Stages must be >= 2");
    end

    logic [Stages-1:0] chain_q;

    // Shift the raw input through the metastability chain.
    always_ff @(posedge clk_i) begin
        chain_q <= {chain_q[Stages-2:0], sync_i};
    end

    assign sync_o = chain_q[Stages-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: synchronizes a bouncy input and commits
// a level change only after a run of stable cycles.
module debounce
    import debounce_pkg::*;
#(
    parameter int   Stages     = 2,
    parameter int   CntWidth   = 16,
    parameter logic ResetLevel = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                async_i,
    input  logic [CntWidth-1:0] cfg_thresh_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                glitch_o
);

    if (CntWidth < 1) begin : g_drc_cnt
        $error("debounce: CntWidth must be >= 1");
    end

    localparam debounce_state_e RstState =
        ResetLevel ? ST_HI : ST_LO;

    logic s;

    sync #(
        .Stages (Stages)
    ) u_sync (
        .clk_i  (clk_i),
        .sync_i (async_i),
        .sync_o (s)
    );

    debounce_state_e state_q, state_d;

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth:0]   cnt_inc;
    logic [CntWidth:0]   thresh_eff;
    logic                commit;

    logic level_q, level_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic glitch_q, glitch_d;

    // Next state: count disagreeing cycles, commit or abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;

        // Threshold 0 behaves as 1; one extra bit keeps
        // the compare free of wrap at the maximum count.
        thresh_eff = (cfg_thresh_i == '0)
                   ? (CntWidth+1)'(1)
                   : {1'b0, cfg_thresh_i};
        cnt_inc    = {1'b0, cnt_q} + (CntWidth+1)'(1);
        commit     = (cnt_inc >= thresh_eff);

        unique case (state_q)
            ST_LO, CONF_HI: begin
                if (s) begin
                    if (commit) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = CONF_HI;
                        cnt_d   = cnt_inc[CntWidth-1:0];
                    end
                end else if (state_q == CONF_HI) begin
                    state_d  = ST_LO;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end
            end
            ST_HI, CONF_LO: begin
                if (!s) begin
                    if (commit) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = CONF_LO;
                        cnt_d   = cnt_inc[CntWidth-1:0];
                    end
                end else if (state_q == CONF_LO) begin
                    state_d  = ST_HI;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end
            end
            default: begin
                state_d = RstState;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RstState;
            cnt_q    <= '0;
            level_q  <= ResetLevel;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign glitch_o = glitch_q;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: run-length model plus
// hand-timed directed checks.
module tb_debounce;

    localparam int STAGES = 2;
    localparam int CW     = 16;

    logic          clk;
    logic          rst;
    logic          async0;
    logic          async1;
    logic [CW-1:0] thresh;

    logic level0, rise0, fall0, glitch0;
    logic level1, rise1, fall1, glitch1;

    debounce #(
        .Stages     (STAGES),
        .CntWidth   (CW),
        .ResetLevel (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .async_i      (async0),
        .cfg_thresh_i (thresh),
        .level_o      (level0),
        .rise_o       (rise0),
        .fall_o       (fall0),
        .glitch_o     (glitch0)
    );

    debounce #(
        .Stages     (STAGES),
        .CntWidth   (CW),
        .ResetLevel (1'b1)
    ) dut_hi (
        .clk_i        (clk),
        .rst_i        (rst),
        .async_i      (async1),
        .cfg_thresh_i (thresh),
        .level_o      (level1),
        .rise_o       (rise1),
        .fall_o       (fall1),
        .glitch_o     (glitch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: s is async0 as seen STAGES edges ago; a
    // level flips once the run of cycles with s != level
    // reaches max(thresh,1); a run ending early is a glitch.
    logic hist[$];
    logic m_level = 1'b0;
    logic m_rise = 1'b0, m_fall = 1'b0, m_glitch = 1'b0;
    int   m_run = 0;
    logic cmp_en = 1'b0;

    initial begin
        for (int i = 0; i < STAGES; i++) hist.push_back(1'b0);
    end

    always @(posedge clk) begin
        logic s;
        int   thr;
        s   = hist[0];
        thr = (thresh == 0) ? 1 : int'(thresh);
        hist.push_back(async0);
        void'(hist.pop_front());
        if (rst) begin
            m_level  <= 1'b0;
            m_run    <= 0;
            m_rise   <= 1'b0;
            m_fall   <= 1'b0;
            m_glitch <= 1'b0;
        end else if (s != m_level) begin
            m_glitch <= 1'b0;
            if (m_run + 1 >= thr) begin
                m_level <= s;
                m_rise  <= s;
                m_fall  <= ~s;
                m_run   <= 0;
            end else begin
                m_rise <= 1'b0;
                m_fall <= 1'b0;
                m_run  <= m_run + 1;
            end
        end else begin
            m_rise   <= 1'b0;
            m_fall   <= 1'b0;
            m_glitch <= (m_run > 0);
            m_run    <= 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en)
            chk("model", {28'd0, level0, rise0, fall0, glitch0},
                {28'd0, m_level, m_rise, m_fall, m_glitch});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        async0 = 1'b0;
        async1 = 1'b1;
        thresh = 16'd4;
        step(5);
        cmp_en = 1'b1;
        rst    = 1'b0;

        // Reset levels hold for 20 cycles on both instances.
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("rst_lvl0", {28'd0, level0, rise0, fall0, glitch0}, 32'h0);
            chk("rst_lvl1", {28'd0, level1, rise1, fall1, glitch1}, 32'h8);
        end

        // Rise after edge 5, fall after edge 5, thresh=4.
        async0 = 1'b1;
        step(5);
        chk("rise_early", {30'd0, level0, rise0}, 32'h0);
        step(1);
        chk("rise_at5", {30'd0, level0, rise0}, 32'h3);
        chk("rise_model", {31'd0, m_rise}, 32'h1);
        step(1);
        chk("rise_after", {30'd0, level0, rise0}, 32'h2);
        step(4);
        async0 = 1'b0;
        step(5);
        chk("fall_early", {30'd0, level0, fall0}, 32'h2);
        step(1);
        chk("fall_at5", {30'd0, level0, fall0}, 32'h1);
        step(1);
        chk("fall_after", {30'd0, level0, fall0}, 32'h0);
        step(4);

        // 3-cycle pulse with thresh=4 aborts as a glitch.
        async0 = 1'b1;
        step(3);
        async0 = 1'b0;
        step(2);
        chk("glitch_early", {31'd0, glitch0}, 32'h0);
        step(1);
        chk("glitch_at5", {29'd0, level0, rise0, glitch0}, 32'h1);
        chk("glitch_model", {31'd0, m_glitch}, 32'h1);
        step(1);
        chk("glitch_after", {29'd0, level0, rise0, glitch0}, 32'h0);
        step(4);

        // thresh=0 and thresh=1 commit on first disagreement.
        thresh = 16'd0;
        step(1);
        async0 = 1'b1;
        step(2);
        chk("t0_early", {31'd0, rise0}, 32'h0);
        step(1);
        chk("t0_rise", {30'd0, level0, rise0}, 32'h3);
        step(6);
        thresh = 16'd1;
        async0 = 1'b0;
        step(2);
        chk("t1_early", {31'd0, fall0}, 32'h0);
        step(1);
        chk("t1_fall", {30'd0, level0, fall0}, 32'h1);
        step(6);

        // thresh=10 lowered to 2 at cnt=5: rise next cycle.
        thresh = 16'd10;
        async0 = 1'b1;
        step(7);
        chk("lower_pre", {30'd0, level0, rise0}, 32'h0);
        thresh = 16'd2;
        step(1);
        chk("lower_rise", {30'd0, level0, rise0}, 32'h3);
        thresh = 16'd10;
        step(5);

        // thresh=10 raised to 20 at cnt=5: fall at cnt=20.
        async0 = 1'b0;
        step(7);
        thresh = 16'd20;
        chk("raise_pre", {30'd0, level0, fall0}, 32'h2);
        step(14);
        chk("raise_early", {30'd0, level0, fall0}, 32'h2);
        step(1);
        chk("raise_fall", {30'd0, level0, fall0}, 32'h1);
        step(4);

        // Reset at cnt=3 discards progress; fresh confirm.
        thresh = 16'd4;
        step(1);
        async0 = 1'b1;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid", {28'd0, level0, rise0, fall0, glitch0}, 32'h0);
        step(3);
        chk("rst_early", {30'd0, level0, rise0}, 32'h0);
        step(1);
        chk("rst_rise", {30'd0, level0, rise0}, 32'h3);
        step(4);

        // Bounce shorter than thresh=3 keeps level high.
        thresh = 16'd3;
        async0 = 1'b0; step(2);
        async0 = 1'b1; step(1);
        async0 = 1'b0; step(2);
        async0 = 1'b1; step(1);
        async0 = 1'b0; step(1);
        async0 = 1'b1; step(6);
        chk("bounce_lvl", {31'd0, level0}, 32'h1);
        async0 = 1'b0;
        step(8);
        chk("settle_lvl", {31'd0, level0}, 32'h0);
        chk("hi_inst_lvl", {31'd0, level1}, 32'h1);

        $display("Result: errors=%0d of %0d checks",
                 n_errors, n_checks);
        $finish;
    end

endmodule
